// File: rtl/aes_req_sequencer_if.sv
// Request/response channels plus the AES core load/done bus.
// slave = sequencer view, master = fabric/core-side view.
interface aes_req_sequencer_if;
  logic         req_valid;
  logic         req_ready;
  logic [127:0] req_key;
  logic [127:0] req_text;
  logic         resp_valid;
  logic         resp_ready;
  logic [127:0] resp_text;
  logic         resp_timeout;
  logic         aes_ld;
  logic [127:0] aes_key;
  logic [127:0] aes_text_in;
  logic         aes_done;
  logic [127:0] aes_text_out;

  modport slave (
    input  req_valid, req_key, req_text,
    input  resp_ready, aes_done, aes_text_out,
    output req_ready, resp_valid, resp_text,
    output resp_timeout, aes_ld, aes_key, aes_text_in
  );

  modport master (
    output req_valid, req_key, req_text,
    output resp_ready, aes_done, aes_text_out,
    input  req_ready, resp_valid, resp_text,
    input  resp_timeout, aes_ld, aes_key, aes_text_in
  );
endinterface

// File: rtl/aes_req_sequencer.sv
// Host-side sequencer for the AES-128 core ld/done interface,
// with a WAIT timeout watchdog and a completed-block counter.
module aes_req_sequencer #(
  parameter int TIMEOUT_CYC = 32,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  aes_req_sequencer_if.slave bus,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt,
  output logic             err_spurious
);

  typedef enum logic [1:0] {
    IDLE, LOAD, WAIT, RESP
  } state_e;

  localparam logic [7:0] TERM = 8'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic [7:0]       timer_q, timer_d;
  logic [127:0]     key_q, key_d;
  logic [127:0]     txt_q, txt_d;
  logic [127:0]     rtxt_q, rtxt_d;
  logic             rto_q, rto_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             rrdy_q, rrdy_d;
  logic             rvld_q, rvld_d;
  logic             ld_q, ld_d;
  logic             busy_q, busy_d;
  logic             req_hs, resp_hs;

  assign req_hs  = bus.req_valid & rrdy_q;
  assign resp_hs = rvld_q & bus.resp_ready;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    key_d   = key_q;
    txt_d   = txt_q;
    rtxt_d  = rtxt_q;
    rto_d   = rto_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_hs) begin
          key_d   = bus.req_key;
          txt_d   = bus.req_text;
          state_d = LOAD;
        end
      end
      LOAD: begin
        timer_d = 8'd0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 8'd1;
        // done has priority over the terminal timer count
        if (bus.aes_done) begin
          rtxt_d  = bus.aes_text_out;
          rto_d   = 1'b0;
          state_d = RESP;
        end else if (timer_q == TERM) begin
          rtxt_d  = '0;
          rto_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_hs) begin
          state_d = IDLE;
          if (!rto_q && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.aes_done && (state_q != WAIT))
      err_d = 1'b1;
    rrdy_d = (state_d == IDLE);
    rvld_d = (state_d == RESP);
    ld_d   = (state_d == LOAD);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      key_q   <= '0;
      txt_q   <= '0;
      rtxt_q  <= '0;
      rto_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rrdy_q  <= 1'b0;
      rvld_q  <= 1'b0;
      ld_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      key_q   <= key_d;
      txt_q   <= txt_d;
      rtxt_q  <= rtxt_d;
      rto_q   <= rto_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rrdy_q  <= rrdy_d;
      rvld_q  <= rvld_d;
      ld_q    <= ld_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.req_ready    = rrdy_q;
  assign bus.resp_valid   = rvld_q;
  assign bus.resp_text    = rtxt_q;
  assign bus.resp_timeout = rto_q;
  assign bus.aes_ld       = ld_q;
  assign bus.aes_key      = key_q;
  assign bus.aes_text_in  = txt_q;
  assign busy             = busy_q;
  assign blk_cnt          = cnt_q;
  assign err_spurious     = err_q;

endmodule

// File: tb/tb_aes_req_sequencer.sv
// Bench for aes_req_sequencer: core stub, transaction-level
// model checked every cycle, plus directed literal checks.
module tb_aes_req_sequencer;
  localparam int TO = 32;
  localparam int CW = 16;

  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_req_sequencer_if bus();
  logic          busy;
  logic [CW-1:0] blk_cnt;
  logic          err_spurious;

  aes_req_sequencer #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .busy(busy),
    .blk_cnt(blk_cnt),
    .err_spurious(err_spurious)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] stub_ct(logic [127:0] k);
    if (k == KB) return CB;
    if (k == KC) return CC;
    return 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a;
  endfunction

  // Core stub: done arrives stub_lat cycles after the ld cycle
  int stub_lat = 10;
  int stub_cnt = -1;
  int ld_cnt   = 0;
  int ld_cyc   = 0;
  int cyc      = 0;
  bit spur_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    bus.aes_done     = 1'b0;
    bus.aes_text_out = 128'hdeaddeaddeaddeaddeaddeaddeaddead;
    if (!rst) begin
      stub_cnt = -1;
    end else begin
      if (spur_req) begin
        bus.aes_done = 1'b1;
        spur_req     = 1'b0;
      end
      if (bus.aes_ld) begin
        ld_cnt++;
        ld_cyc   = cyc;
        stub_cnt = stub_lat;
      end else if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          bus.aes_done     = 1'b1;
          bus.aes_text_out = stub_ct(bus.aes_key);
          stub_cnt         = -1;
        end
      end
    end
  end

  // Model: phase 0 idle, 1 loading, 2 waiting, 3 responding
  int            m_ph;
  bit            m_fresh;
  int            m_wait;
  logic [127:0]  m_key, m_pt, m_text;
  bit            m_to, m_err;
  logic [CW-1:0] m_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ph <= 0; m_fresh <= 1'b1; m_wait <= 0;
      m_key <= '0; m_pt <= '0; m_text <= '0;
      m_to <= 1'b0; m_err <= 1'b0; m_cnt <= '0;
    end else begin
      m_fresh <= 1'b0;
      if (bus.aes_done === 1'b1 && m_ph != 2) m_err <= 1'b1;
      case (m_ph)
        0: if (!m_fresh && bus.req_valid) begin
          m_key <= bus.req_key;
          m_pt  <= bus.req_text;
          m_ph  <= 1;
        end
        1: begin
          m_ph   <= 2;
          m_wait <= 0;
        end
        2: begin
          m_wait <= m_wait + 1;
          if (bus.aes_done === 1'b1) begin
            m_text <= bus.aes_text_out; m_to <= 1'b0; m_ph <= 3;
          end else if (m_wait + 1 == TO) begin
            m_text <= '0; m_to <= 1'b1; m_ph <= 3;
          end
        end
        default: if (bus.resp_ready) begin
          m_ph <= 0;
          if (!m_to && m_cnt != {CW{1'b1}}) m_cnt <= m_cnt + 1'b1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("req_ready", bus.req_ready, m_ph == 0 && !m_fresh);
      chk("resp_valid", bus.resp_valid, m_ph == 3);
      chk("aes_ld", bus.aes_ld, m_ph == 1);
      chk("busy", busy, m_ph != 0);
      chk("blk_cnt", blk_cnt, m_cnt);
      chk("err_spurious", err_spurious, m_err);
      chk("aes_key", bus.aes_key, m_key);
      chk("aes_text_in", bus.aes_text_in, m_pt);
      if (m_ph == 3) begin
        chk("resp_text", bus.resp_text, m_text);
        chk("resp_timeout", bus.resp_timeout, m_to);
      end
    end
  end

  task automatic send(logic [127:0] k, logic [127:0] p);
    bit ok = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_key   = k;
    bus.req_text  = p;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    bus.req_valid = 1'b0;
    chk("req_accepted", ok, 1'b1);
  endtask

  task automatic wait_resp();
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.resp_valid) ok = 1'b1;
    end
    chk("resp_seen", ok, 1'b1);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 1'b0);
    chk({tag, "_resp_valid"}, bus.resp_valid, 1'b0);
    chk({tag, "_aes_ld"}, bus.aes_ld, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_blk_cnt"}, blk_cnt, '0);
    chk({tag, "_err"}, err_spurious, 1'b0);
    chk({tag, "_aes_key"}, bus.aes_key, '0);
    chk({tag, "_aes_text_in"}, bus.aes_text_in, '0);
    chk({tag, "_resp_text"}, bus.resp_text, '0);
    chk({tag, "_resp_timeout"}, bus.resp_timeout, 1'b0);
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_key      = '0;
    bus.req_text     = '0;
    bus.resp_ready   = 1'b0;
    bus.aes_done     = 1'b0;
    bus.aes_text_out = '0;
    #1 rst = 1'b0;
    #2 chk_zero("rst0");
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;

    // App. B known answer
    stub_lat       = 10;
    bus.resp_ready = 1'b1;
    send(KB, PB);
    wait_resp();
    chk("b_text", bus.resp_text, CB);
    chk("b_to", bus.resp_timeout, 1'b0);
    @(posedge clk); #1;
    chk("b_cnt", blk_cnt, 16'd1);
    chk("b_ld_pulses", ld_cnt, 1);

    // App. C.1 with backpressure
    bus.resp_ready = 1'b0;
    send(KC, PC);
    wait_resp();
    for (int i = 0; i < 10; i++) begin
      chk("c_valid", bus.resp_valid, 1'b1);
      chk("c_text", bus.resp_text, CC);
      chk("c_req_ready", bus.req_ready, 1'b0);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("c_cnt", blk_cnt, 16'd2);

    // timeout: core never completes
    stub_lat = -1;
    send(KB, PB);
    wait_resp();
    chk("to_latency", cyc - ld_cyc, 33);
    chk("to_flag", bus.resp_timeout, 1'b1);
    chk("to_text", bus.resp_text, '0);
    @(posedge clk); #1;
    chk("to_cnt", blk_cnt, 16'd2);

    // done on the terminal timer cycle wins
    stub_lat = 32;
    send(KB, PB);
    wait_resp();
    chk("edge_latency", cyc - ld_cyc, 33);
    chk("edge_to", bus.resp_timeout, 1'b0);
    chk("edge_text", bus.resp_text, CB);
    @(posedge clk); #1;
    chk("edge_cnt", blk_cnt, 16'd3);

    // spurious done while idle
    chk("sp_before", err_spurious, 1'b0);
    @(negedge clk);
    spur_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("sp_err", err_spurious, 1'b1);
    chk("sp_busy", busy, 1'b0);
    chk("sp_valid", bus.resp_valid, 1'b0);
    chk("sp_ready", bus.req_ready, 1'b1);
    repeat (3) @(negedge clk);
    chk("sp_sticky", err_spurious, 1'b1);

    // asynchronous reset in WAIT
    stub_lat = -1;
    send(KC, PC);
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1 chk_zero("arst");
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    stub_lat = 10;
    send(KB, PB);
    wait_resp();
    chk("r_text", bus.resp_text, CB);
    chk("r_to", bus.resp_timeout, 1'b0);
    @(posedge clk); #1;
    chk("r_cnt", blk_cnt, 16'd1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
